// File: rtl/rqst_dispatcher_if.sv
// Register-bus write port plus the channel request/done handshake of rqst_dispatcher.
// The master side is the register-bus host together with the data sender; the slave side is the dispatcher.
interface rqst_dispatcher_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int N_CH   = 2
);
  logic [ADDR_W-1:0] si_addr;
  logic [DATA_W-1:0] si_data;
  logic              si_rdy;
  logic [N_CH-1:0]   ch_rqst_o;
  logic              ch_done_i;

  modport master (output si_addr, si_data, si_rdy, ch_done_i, input ch_rqst_o);
  modport slave  (input si_addr, si_data, si_rdy, ch_done_i, output ch_rqst_o);
endinterface

// File: rtl/rqst_dispatcher.sv
// Decodes request-register writes into command pulses and serves queued channel requests round-robin.
// Optional service timeout is enabled by defining RQST_TIMEOUT_EN.
module rqst_dispatcher #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int MY_ADDR        = 0,
  parameter int N_CH           = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic            clk,
  input  logic            rst,
  rqst_dispatcher_if.slave bus,
  output logic            start_o,
  output logic            stop_o,
  output logic            running_o,
  output logic            trig_rqst_o,
  output logic            reset_o,
  output logic [N_CH-1:0] pending_o,
  output logic            busy_o,
  output logic            timeout_o
);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [N_CH-1:0]   grant_oh;
  logic [N_CH-1:0]   ch_field;
  logic [N_CH-1:0]   pend_clr;
  logic [N_CH-1:0]   pend_nxt;
  logic              grant_vld;
  logic              wr;
  logic              wr_rst;
  logic              do_stop;
  logic              do_start;

  assign wr       = bus.si_rdy && (bus.si_addr == REG_ADDR_WIDTH'(MY_ADDR));
  assign wr_rst   = wr && bus.si_data[3];
  assign ch_field = bus.si_data[4 +: N_CH];
  // Any channel request forces a stop so acquisition RAM is quiet before readout.
  assign do_stop  = bus.si_data[1] || (|ch_field);
  assign do_start = bus.si_data[0] && !bus.si_data[1] && !(|ch_field) && !busy_o;
  assign busy_o   = (state != IDLE) || (|pending_o);

  generate
    if (REG_DATA_WIDTH > 4 + N_CH) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^bus.si_data[REG_DATA_WIDTH-1:4+N_CH];
    end
  endgenerate

  always_comb begin
    int j;
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    j         = 0;
    for (int i = 0; i < N_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (!grant_vld && pending_o[j]) begin
        grant_vld   = 1'b1;
        grant_oh[j] = 1'b1;
        grant_idx   = PTR_W'(j);
      end
    end
  end

  assign next_ptr = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
  // A new request for the channel being granted this cycle survives the clear and is served again.
  assign pend_clr = (state == IDLE && grant_vld) ? grant_oh : '0;
  assign pend_nxt = (pending_o & ~pend_clr) | (wr ? ch_field : '0);

`ifdef RQST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;
  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || wr_rst) begin
      state         <= IDLE;
      ptr           <= '0;
      pending_o     <= '0;
      bus.ch_rqst_o <= '0;
      start_o       <= 1'b0;
      stop_o        <= 1'b0;
      trig_rqst_o   <= 1'b0;
      running_o     <= 1'b0;
      reset_o       <= !rst;
`ifdef RQST_TIMEOUT_EN
      cnt           <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      start_o     <= wr && do_start;
      stop_o      <= wr && do_stop;
      trig_rqst_o <= wr && bus.si_data[2];
      reset_o     <= 1'b0;
      if (wr && do_stop)       running_o <= 1'b0;
      else if (wr && do_start) running_o <= 1'b1;
      pending_o <= pend_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            bus.ch_rqst_o <= grant_oh;
            ptr           <= next_ptr;
            state         <= BUSY;
`ifdef RQST_TIMEOUT_EN
            cnt           <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.ch_done_i) begin
            bus.ch_rqst_o <= '0;
            state         <= IDLE;
          end
`ifdef RQST_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.ch_rqst_o <= '0;
            state         <= IDLE;
            timeout_q     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rqst_dispatcher.sv
// Directed bench for rqst_dispatcher: a cycle-by-cycle vector table plus hand-written reset and timeout sequences.
module tb_rqst_dispatcher;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_o, stop_o, running_o, trig_rqst_o, reset_o, busy_o, timeout_o;
  logic [1:0] pending_o;

`ifdef RQST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  rqst_dispatcher_if #(.ADDR_W(8), .DATA_W(16), .N_CH(2)) bus ();

  rqst_dispatcher #(
    .REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(16), .MY_ADDR(0), .N_CH(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .start_o(start_o), .stop_o(stop_o), .running_o(running_o), .trig_rqst_o(trig_rqst_o),
    .reset_o(reset_o), .pending_o(pending_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // exp = {start, stop, running, trig, reset, ch_rqst[1:0], pending[1:0], busy}
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        rdy;
    logic        done;
    logic [9:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   held;

  function automatic vec_t mk(logic [7:0] a, logic [15:0] d, logic r, logic dn, logic [9:0] e);
    vec_t v;
    v.addr = a; v.data = d; v.rdy = r; v.done = dn; v.exp = e;
    return v;
  endfunction

  function automatic vec_t w_v(logic [15:0] d, logic [9:0] e);
    return mk(8'd0, d, 1'b1, 1'b0, e);
  endfunction

  function automatic vec_t i_v(logic [9:0] e);
    return mk(8'd0, 16'd0, 1'b0, 1'b0, e);
  endfunction

  function automatic vec_t d_v(logic [9:0] e);
    return mk(8'd0, 16'd0, 1'b0, 1'b1, e);
  endfunction

  function automatic logic [9:0] snap();
    return {start_o, stop_o, running_o, trig_rqst_o, reset_o, bus.ch_rqst_o, pending_o, busy_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] a, input logic [15:0] d, input logic r, input logic dn);
    @(negedge clk);
    bus.si_addr   = a;
    bus.si_data   = d;
    bus.si_rdy    = r;
    bus.ch_done_i = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    cyc(8'd0, d, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cyc(8'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic done();
    cyc(8'd0, 16'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.si_addr = '0; bus.si_data = '0; bus.si_rdy = 1'b0; bus.ch_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {snap(), timeout_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(w_v(16'h0001, 10'b1_0_1_0_0_00_00_0));        // start while idle
    tbl.push_back(i_v(10'b0_0_1_0_0_00_00_0));                   // pulse is one cycle
    tbl.push_back(mk(8'd1, 16'h0001, 1'b1, 1'b0, 10'b0_0_1_0_0_00_00_0)); // wrong address
    tbl.push_back(w_v(16'h0030, 10'b0_1_0_0_0_00_11_1));        // both channels
    tbl.push_back(i_v(10'b0_0_0_0_0_01_10_1));
    tbl.push_back(i_v(10'b0_0_0_0_0_01_10_1));
    tbl.push_back(d_v(10'b0_0_0_0_0_00_10_1));
    tbl.push_back(i_v(10'b0_0_0_0_0_10_00_1));                   // one idle gap, then ch1
    tbl.push_back(d_v(10'b0_0_0_0_0_00_00_0));
    tbl.push_back(i_v(10'b0_0_0_0_0_00_00_0));
    tbl.push_back(w_v(16'h0010, 10'b0_1_0_0_0_00_01_1));
    tbl.push_back(i_v(10'b0_0_0_0_0_01_00_1));
    tbl.push_back(w_v(16'h0010, 10'b0_1_0_0_0_01_01_1));        // re-queue channel in service
    tbl.push_back(w_v(16'h0001, 10'b0_0_0_0_0_01_01_1));        // start dropped while busy
    tbl.push_back(d_v(10'b0_0_0_0_0_00_01_1));
    tbl.push_back(i_v(10'b0_0_0_0_0_01_00_1));                   // ch0 served again
    tbl.push_back(d_v(10'b0_0_0_0_0_00_00_0));
    tbl.push_back(w_v(16'h0003, 10'b0_1_0_0_0_00_00_0));        // start+stop -> stop only
    tbl.push_back(w_v(16'h0001, 10'b1_0_1_0_0_00_00_0));
    tbl.push_back(w_v(16'h0004, 10'b0_0_1_1_0_00_00_0));        // trig only
    tbl.push_back(w_v(16'h0003, 10'b0_1_0_0_0_00_00_0));
    tbl.push_back(w_v(16'h0010, 10'b0_1_0_0_0_00_01_1));
    tbl.push_back(i_v(10'b0_0_0_0_0_01_00_1));
    tbl.push_back(w_v(16'h0020, 10'b0_1_0_0_0_01_10_1));
    tbl.push_back(w_v(16'h0038, 10'b0_0_0_0_1_00_00_0));        // RST write while busy
    tbl.push_back(i_v(10'b0_0_0_0_0_00_00_0));
    tbl.push_back(w_v(16'h0030, 10'b0_1_0_0_0_00_11_1));
    tbl.push_back(w_v(16'h0010, 10'b0_1_0_0_0_01_11_1));        // write in grant cycle, pointer at 0
    tbl.push_back(d_v(10'b0_0_0_0_0_00_11_1));
    tbl.push_back(i_v(10'b0_0_0_0_0_10_01_1));
    tbl.push_back(d_v(10'b0_0_0_0_0_00_01_1));
    tbl.push_back(i_v(10'b0_0_0_0_0_01_00_1));
    tbl.push_back(d_v(10'b0_0_0_0_0_00_00_0));
    tbl.push_back(d_v(10'b0_0_0_0_0_00_00_0));                   // done ignored in idle
    tbl.push_back(mk(8'd1, 16'h0030, 1'b1, 1'b0, 10'b0_0_0_0_0_00_00_0));
    tbl.push_back(mk(8'd0, 16'h0001, 1'b0, 1'b0, 10'b0_0_0_0_0_00_00_0)); // no strobe
    tbl.push_back(w_v(16'h0001, 10'b1_0_1_0_0_00_00_0));
    tbl.push_back(w_v(16'h000D, 10'b0_0_0_0_1_00_00_0));        // RST masks start/trig
    tbl.push_back(w_v(16'h0005, 10'b1_0_1_1_0_00_00_0));
    tbl.push_back(w_v(16'h0006, 10'b0_1_0_1_0_00_00_0));
    tbl.push_back(w_v(16'h0040, 10'b0_0_0_0_0_00_00_0));        // bit above channel field

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].addr, tbl[i].data, tbl[i].rdy, tbl[i].done);
      check($sformatf("vec%0d", i), {22'd0, snap()}, {22'd0, tbl[i].exp});
    end
    check("no_timeout_after_table", {31'd0, timeout_o}, 32'd0);

    // rst before the pending grant clears everything and rewinds the pointer
    wr(16'h0030);
    check("pre_rst_pending", {30'd0, pending_o}, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("sync_rst_clears", {snap(), timeout_o}, 32'd0);
    rst = 1'b0;
    wr(16'h0030);
    idle();
    check("ptr_after_rst", {30'd0, bus.ch_rqst_o}, 32'd1);
    done();
    idle();
    check("second_grant_ch1", {30'd0, bus.ch_rqst_o}, 32'd2);
    done();
    check("drained_not_busy", {31'd0, busy_o}, 32'd0);

    // service with no done: aborts after 16 cycles only when the timeout is built in
    wr(16'h0020);
    idle();
    check("ch1_granted", {30'd0, bus.ch_rqst_o}, 32'd2);
    held = 1;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (bus.ch_rqst_o == 2'b10) held++;
    end
    check("rqst_hold_cycles", held, TO_EN ? 32'd16 : 32'd41);
    check("timeout_flag", {31'd0, timeout_o}, {31'd0, TO_EN});
    check("pending_not_requeued", {30'd0, pending_o}, 32'd0);
    check("busy_after_hold", {31'd0, busy_o}, {31'd0, !TO_EN});
    if (!TO_EN) done();
    check("ch_released", {30'd0, bus.ch_rqst_o}, 32'd0);
    repeat (3) idle();
    check("timeout_sticky", {31'd0, timeout_o}, {31'd0, TO_EN});
    wr(16'h0008);
    check("rst_write_pulse", {31'd0, reset_o}, 32'd1);
    check("rst_write_clears_timeout", {31'd0, timeout_o}, 32'd0);
    idle();
    check("final_idle", {snap(), timeout_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rqst_dispatcher.md
Name: rqst_dispatcher

Overview:
- Parametrised successor to the single-register request decoder. Decodes PC request-register writes into one-cycle command pulses and a latched acquisition run state.
- Channel data requests for N_CH channels are queued and issued one at a time to the data-sender path, with a done handshake.
- Sits between the simple-interface register bus and the acquisition, trigger and data-sender blocks.

Parameters:
- REG_ADDR_WIDTH, 8: simple-interface address width.
- REG_DATA_WIDTH, 16: simple-interface data width. Must be >= 4+N_CH.
- MY_ADDR, 0: address this block responds to.
- N_CH, 2: number of channels, 1..8.
- TIMEOUT_CYCLES, 65535: service timeout in clk cycles. Used only with RQST_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- si_addr  in  REG_ADDR_WIDTH  write address
- si_data  in  REG_DATA_WIDTH  write data
- si_rdy  in  1  write strobe, one cycle
- start_o  out  1  start pulse
- stop_o  out  1  stop pulse
- running_o  out  1  acquisition-running level
- trig_rqst_o  out  1  trigger-status request pulse
- reset_o  out  1  soft-reset pulse
- ch_rqst_o  out  N_CH  one-hot channel request, held until done
- ch_done_i  in  1  data sender finished the current channel
- pending_o  out  N_CH  queued, not-yet-issued channel requests
- busy_o  out  1  high when FSM is not IDLE or pending_o != 0
- timeout_o  out  1  sticky timeout flag

Behaviour:
- Bit map: 0 START, 1 STOP, 2 TRIG, 3 RST, 4+k CH k. Bits above 3+N_CH are ignored.
- Accepted write: si_rdy=1 and si_addr==MY_ADDR. Any other write is ignored.
- Pulse outputs assert on the cycle after an accepted write, are exactly 1 cycle wide, and are 0 otherwise.
- On rst, all outputs go to 0, the FSM goes to IDLE, pending clears, and the round-robin pointer resets to channel 0.
- RST bit: reset_o pulses; running_o, pending, FSM and pointer clear as on rst; timeout_o clears. All other bits of that write are ignored.
- stop_o pulses if STOP=1 or any CH bit=1. This guarantees RAM writing stops before readout.
- start_o pulses only if START=1, STOP=0, all CH bits=0 and busy_o=0. Otherwise START is dropped: no pulse, running_o unchanged.
- running_o: set by an issued start_o, cleared by any stop_o, on the same cycle as the pulse.
- trig_rqst_o pulses if TRIG=1. It is independent of all other bits except RST.
- Pending: pending |= CH bits on an accepted write. Duplicate requests merge.
- Requesting the channel currently in service re-queues it; it is served again after the current service completes.
- FSM IDLE:
  - If pending != 0, grant the first set bit searching round-robin from pointer.
  - Next cycle: ch_rqst_o = one-hot(grant), the granted pending bit clears, pointer = grant+1 mod N_CH, state BUSY.
- FSM BUSY:
  - Hold ch_rqst_o until ch_done_i=1 is sampled.
  - Next cycle: ch_rqst_o=0, state IDLE. The next grant needs at least 1 IDLE cycle, so consecutive requests have a 1-cycle gap.
- ch_done_i is ignored in IDLE.
- An accepted write arriving in the same cycle as a grant is merged into pending without loss.
- Only one bit of ch_rqst_o is ever high.

Optional Feature:
- Macro RQST_TIMEOUT_EN.
- Defined: a counter runs in BUSY and resets on entry. If it reaches TIMEOUT_CYCLES without ch_done_i, the block:
  - drops ch_rqst_o,
  - returns to IDLE,
  - sets timeout_o=1, which stays set until rst or an RST write.
  - The aborted channel is not re-queued.
- Not defined: no counter; BUSY waits indefinitely; timeout_o is tied 0.

Test Plan:
- Write 0x0001 to MY_ADDR with busy_o=0 -> start_o 1-cycle pulse one cycle later, running_o=1. Same data to MY_ADDR+1 -> no response.
- running_o=1, write 0x0030 (N_CH=2):
  - stop_o pulse, running_o=0, pending_o=2'b11.
  - ch_rqst_o=2'b01 until ch_done_i, then 1 idle cycle.
  - Then ch_rqst_o=2'b10; after its done, busy_o=0.
- In BUSY on ch0, write 0x0010 -> pending_o=2'b01; after ch0 done, ch0 is served a second time. Also write 0x0001 while busy -> no start_o.
- Write 0x0003 -> stop_o pulse only, no start_o. Write 0x0004 -> trig_rqst_o pulse only.
- In BUSY with pending 2'b10, write 0x0038 -> reset_o pulse only; next cycle ch_rqst_o=0, pending_o=0, running_o=0, no stop_o.
- With RQST_TIMEOUT_EN and TIMEOUT_CYCLES=16, request ch1 and never assert done -> ch_rqst_o drops after 16 cycles, timeout_o=1 and stays set; a later 0x0008 write clears it.
